nxn_game_core: RTL

// Parametrised N x N, K-in-a-row two-player board engine: successor of the fixed 3x3 tic-tac-toe logic.

---
 rtl/nxn_game_core.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/nxn_game_core.sv
// nxn_game_core: N x N, K-in-a-row two-player board engine.
// Holds the board, arbitrates turns, rejects illegal moves and scans for a
// win or draw one cell per cycle around the most recently placed stone.
// Display logic reads any cell through the combinational rd port.
module nxn_game_core #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int RW = (N <= 2) ? 1 : $clog2(N),
    parameter int CW = $clog2(N * N + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          new_game,
    input  logic          first_player,
    input  logic          move_valid,
    input  logic [RW-1:0] move_row,
    input  logic [RW-1:0] move_col,
    output logic          move_ready,
    output logic          move_done,
    output logic          move_ok,
    input  logic [RW-1:0] rd_row,
    input  logic [RW-1:0] rd_col,
    output logic [1:0]    rd_cell,
    output logic          turn,
    output logic [1:0]    winner,
    output logic          draw,
    output logic          game_over,
    output logic [CW-1:0] move_count
);

    // Signed width for probe coordinates: room for r0 + (K-1) and r0 - (K-1).
    localparam int SW    = RW + 2;
    localparam int CELLS = N * N;
    localparam int IW    = (CELLS <= 2) ? 1 : $clog2(CELLS);

    typedef enum logic [1:0] {
        ST_READY = 2'b00,
        ST_CHECK = 2'b01,
        ST_OVER  = 2'b10
    } state_t;

    // Linear cell index of (row, col); only meaningful for in-range coordinates.
    function automatic logic [IW-1:0] cell_index(input logic [RW-1:0] row,
                                                 input logic [RW-1:0] col);
        return IW'(32'(row) * 32'(N) + 32'(col));
    endfunction

    // True when a row or column index lies inside the board.
    function automatic logic coord_in_range(input logic [RW-1:0] v);
        return (32'(v) < 32'(N));
    endfunction

    // Two-bit owner code stored at a linear cell index.
    function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b,
                                           input logic [IW-1:0]      idx);
        return b[{idx, 1'b0} +: 2];
    endfunction

    state_t               state_r;
    logic [2*CELLS-1:0]   board_r;
    logic                 turn_r;
    logic [1:0]           winner_r;
    logic                 draw_r;
    logic                 game_over_r;
    logic                 move_done_r;
    logic                 move_ok_r;
    logic                 move_ready_r;
    logic [CW-1:0]        move_count_r;
    logic [RW-1:0]        r0_r;
    logic [RW-1:0]        c0_r;
    logic [1:0]           dir_r;
    logic                 side_r;
    logic [SW-1:0]        step_r;
    logic [SW-1:0]        run_r;

    logic [1:0]           mover_code_s;
    logic [IW-1:0]        req_idx_s;
    logic                 req_legal_s;
    logic signed [SW-1:0] step_s;
    logic signed [SW-1:0] row_off_s;
    logic signed [SW-1:0] col_off_s;
    logic signed [SW-1:0] probe_row_s;
    logic signed [SW-1:0] probe_col_s;
    logic                 probe_in_s;
    logic [IW-1:0]        probe_idx_s;
    logic                 probe_match_s;
    logic [SW-1:0]        run_inc_s;
    logic [SW-1:0]        step_inc_s;
    logic                 win_s;
    logic                 side_cont_s;

    assign move_ready = move_ready_r;
    assign move_done  = move_done_r;
    assign move_ok    = move_ok_r;
    assign turn       = turn_r;
    assign winner     = winner_r;
    assign draw       = draw_r;
    assign game_over  = game_over_r;
    assign move_count = move_count_r;

    // Legality of the incoming request: on the board and on an empty cell.
    always_comb begin
        mover_code_s = turn_r ? 2'b10 : 2'b01;
        req_idx_s    = cell_index(move_row, move_col);
        if (coord_in_range(move_row) && coord_in_range(move_col)) begin
            req_legal_s = (cell_at(board_r, req_idx_s) == 2'b00);
        end else begin
            req_legal_s = 1'b0;
        end
    end

    // Probe cell for the current scan position and the resulting scan decision.
    always_comb begin
        step_s = $signed(step_r);
        case (dir_r)
            2'd0: begin row_off_s = {SW{1'b0}}; col_off_s = step_s;      end
            2'd1: begin row_off_s = step_s;     col_off_s = {SW{1'b0}}; end
            2'd2: begin row_off_s = step_s;     col_off_s = step_s;      end
            2'd3: begin row_off_s = step_s;     col_off_s = -step_s;     end
            default: begin row_off_s = {SW{1'b0}}; col_off_s = {SW{1'b0}}; end
        endcase
        probe_row_s = side_r ? ($signed({2'b00, r0_r}) - row_off_s)
                             : ($signed({2'b00, r0_r}) + row_off_s);
        probe_col_s = side_r ? ($signed({2'b00, c0_r}) - col_off_s)
                             : ($signed({2'b00, c0_r}) + col_off_s);
        probe_in_s  = !probe_row_s[SW-1] && (probe_row_s[SW-2:0] < (SW-1)'(N)) &&
                      !probe_col_s[SW-1] && (probe_col_s[SW-2:0] < (SW-1)'(N));
        probe_idx_s = cell_index(probe_row_s[RW-1:0], probe_col_s[RW-1:0]);
        if (probe_in_s) begin
            probe_match_s = (cell_at(board_r, probe_idx_s) == mover_code_s);
        end else begin
            probe_match_s = 1'b0;
        end
        run_inc_s   = run_r + SW'(1'b1);
        step_inc_s  = step_r + SW'(1'b1);
        win_s       = probe_match_s && (run_inc_s == SW'(K));
        side_cont_s = probe_match_s && (step_inc_s <= SW'(K - 1));
    end

    // Display read port: empty for any out-of-range coordinate.
    always_comb begin
        if (coord_in_range(rd_row) && coord_in_range(rd_col)) begin
            rd_cell = cell_at(board_r, cell_index(rd_row, rd_col));
        end else begin
            rd_cell = 2'b00;
        end
    end

    // Game FSM: move acceptance, line scan, win/draw resolution and restart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_READY;
            board_r      <= {(2*CELLS){1'b0}};
            turn_r       <= 1'b0;
            winner_r     <= 2'b00;
            draw_r       <= 1'b0;
            game_over_r  <= 1'b0;
            move_done_r  <= 1'b0;
            move_ok_r    <= 1'b0;
            move_ready_r <= 1'b1;
            move_count_r <= {CW{1'b0}};
            r0_r         <= {RW{1'b0}};
            c0_r         <= {RW{1'b0}};
            dir_r        <= 2'd0;
            side_r       <= 1'b0;
            step_r       <= SW'(1'b1);
            run_r        <= SW'(1'b1);
        end else if (new_game) begin
            state_r      <= ST_READY;
            board_r      <= {(2*CELLS){1'b0}};
            turn_r       <= first_player;
            winner_r     <= 2'b00;
            draw_r       <= 1'b0;
            game_over_r  <= 1'b0;
            move_done_r  <= 1'b0;
            move_ok_r    <= 1'b0;
            move_ready_r <= 1'b1;
            move_count_r <= {CW{1'b0}};
            dir_r        <= 2'd0;
            side_r       <= 1'b0;
            step_r       <= SW'(1'b1);
            run_r        <= SW'(1'b1);
        end else begin
            move_done_r <= 1'b0;
            move_ok_r   <= 1'b0;
            case (state_r)
                ST_READY: begin
                    if (move_valid) begin
                        if (!req_legal_s) begin
                            move_done_r <= 1'b1;
                            move_ok_r   <= 1'b0;
                        end else begin
                            board_r[{req_idx_s, 1'b0} +: 2] <= mover_code_s;
                            move_count_r <= move_count_r + CW'(1'b1);
                            r0_r         <= move_row;
                            c0_r         <= move_col;
                            dir_r        <= 2'd0;
                            side_r       <= 1'b0;
                            step_r       <= SW'(1'b1);
                            run_r        <= SW'(1'b1);
                            move_ready_r <= 1'b0;
                            state_r      <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (win_s) begin
                        winner_r    <= mover_code_s;
                        game_over_r <= 1'b1;
                        move_done_r <= 1'b1;
                        move_ok_r   <= 1'b1;
                        state_r     <= ST_OVER;
                    end else if (side_cont_s) begin
                        run_r  <= run_inc_s;
                        step_r <= step_inc_s;
                    end else if (!side_r) begin
                        // Switch to the opposite side; the run carries over so both
                        // halves of the line are summed.
                        side_r <= 1'b1;
                        step_r <= SW'(1'b1);
                        run_r  <= probe_match_s ? run_inc_s : run_r;
                    end else if (dir_r != 2'd3) begin
                        dir_r  <= dir_r + 2'd1;
                        side_r <= 1'b0;
                        step_r <= SW'(1'b1);
                        run_r  <= SW'(1'b1);
                    end else begin
                        move_done_r <= 1'b1;
                        move_ok_r   <= 1'b1;
                        if (move_count_r == CW'(CELLS)) begin
                            draw_r      <= 1'b1;
                            game_over_r <= 1'b1;
                            state_r     <= ST_OVER;
                        end else begin
                            turn_r       <= ~turn_r;
                            move_ready_r <= 1'b1;
                            state_r      <= ST_READY;
                        end
                    end
                end
                ST_OVER: begin
                    state_r <= ST_OVER;
                end
                default: begin
                    state_r      <= ST_READY;
                    move_ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule
